// File: rtl/hsi_encoder.sv
// HSI serial frame encoder: buffered byte handshake feeding a tick-driven
// START/DATA/PARITY/GUARD/EOM serialiser. Define HSI_ENC_FIFO_EN for a 4-deep input FIFO.
module hsi_encoder #(
  parameter string ML_FST = "LSB"
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_en,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       q,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_GUARD,
    S_EOM
  } state_e;

  localparam bit MSB_FIRST = (ML_FST == "MSB");

  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic [7:0] w_head_data;
  logic       w_head_last;

  assign w_push = data_valid & data_ready;

`ifdef HSI_ENC_FIFO_EN
  logic [8:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;

  // NOTE: the storage array has no reset; r_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {data_last, data};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end

  assign data_ready                 = (r_count != 3'd4);
  assign w_empty                    = (r_count == 3'd0);
  assign {w_head_last, w_head_data} = r_mem[r_rd_ptr];
`else
  logic       r_full;
  logic [8:0] r_hold;

  always_ff @(posedge clk) begin
    if (w_push) r_hold <= {data_last, data};
  end

  // Push and pop are mutually exclusive: push needs empty, pop needs full.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      r_full <= 1'b0;
    else if (w_push) r_full <= 1'b1;
    else if (w_pop)  r_full <= 1'b0;
  end

  assign data_ready                 = ~r_full;
  assign w_empty                    = ~r_full;
  assign {w_head_last, w_head_data} = r_hold;
`endif

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [7:0] r_byte;
  logic       r_last;
  logic       r_q;
  logic       w_q_nxt;
  logic       r_underrun;
  logic       w_underrun_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_q        <= 1'b1;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_q        <= w_q_nxt;
      r_underrun <= w_underrun_nxt;
      if (w_pop) begin
        r_byte <= w_head_data;
        r_last <= w_head_last;
      end
    end
  end

  // Each phase lasts 8 ticks; r_cnt rolls 7->0 by itself at every phase change.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    if (clk_en) begin
      w_cnt_nxt = r_cnt + 3'd1;
      unique case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          if (r_cnt == 3'd7) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end
        end
        S_DATA: begin
          if (r_cnt == 3'd7) begin
            w_idx_nxt = r_idx + 3'd1;
            if (r_idx == 3'd7) w_state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
          if (r_cnt == 3'd7) begin
            w_state_nxt = r_last ? S_EOM : S_GUARD;
            w_idx_nxt   = '0;
          end
        end
        S_GUARD: begin
          // r_cnt==2 marks a stalled guard waiting for the next byte.
          if (r_cnt != 3'd0) begin
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = 3'd2;
            end
          end
        end
        S_EOM: begin
          if (r_cnt == 3'd7) begin
            w_idx_nxt = r_idx + 3'd1;
            if (r_idx == 3'd1) begin
              w_state_nxt = S_IDLE;
              w_idx_nxt   = '0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Line level is computed for the phase being entered, then registered on the tick.
  always_comb begin
    w_q_nxt        = r_q;
    w_underrun_nxt = clk_en & (r_state == S_GUARD) & (r_cnt == 3'd1) & w_empty;
    if (clk_en) begin
      unique case (w_state_nxt)
        S_START:  w_q_nxt = 1'b0;
        S_DATA:   w_q_nxt = MSB_FIRST ? r_byte[3'd7 - w_idx_nxt] : r_byte[w_idx_nxt];
        S_PARITY: w_q_nxt = ~^r_byte;
        default:  w_q_nxt = 1'b1;
      endcase
    end
  end

  assign q        = r_q;
  assign busy     = (r_state != S_IDLE);
  assign underrun = r_underrun;

endmodule
